qosc_ctrl: RTL and testbench
============================

QOSC_CTRL -- requirements
Module: qosc_ctrl

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 2, number of cycles load is held high per (re)load, range 1..15.
REQ-002 SHALL have ports clk in 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst in 1: asynchronous, active-high reset.
REQ-004 SHALL have ports cfg_valid in 1, cfg_ready out 1, cfg_addr in 3, cfg_data in 8 as the register write handshake.
REQ-005 SHALL have ports start in 1 and stop in 1 as single-cycle run commands.
REQ-006 SHALL have ports accu_re in 8 and accu_im in 8, signed two's-complement oscillator state fed back from the oscillator.
REQ-007 SHALL have ports load out 1, re_coeff out 8, im_coeff out 8, power out 8, accu_re_init out 8 and accu_im_init out 8 driving the oscillator.
REQ-008 SHALL have ports sample_valid out 1, busy out 1, state out 2 and relock_cnt out 8 as status.

Function
REQ-009 SHALL hold registers: 0 re_coeff, 1 im_coeff, 2 power, 3 accu_re_init, 4 accu_im_init, 5 decim, 6 tol; addr 7 is accepted and discarded.
REQ-010 SHALL write cfg_data into the register at cfg_addr on a cycle with cfg_valid && cfg_ready; the new value appears on outputs the next cycle.
REQ-011 SHALL drive cfg_ready=1 only in IDLE; while cfg_ready=0, cfg_valid is ignored and no register changes.
REQ-012 SHALL implement FSM IDLE(0), LOAD(1), RUN(2), RELOAD(3), encoded on state; busy=1 in all states except IDLE.
REQ-013 SHALL go IDLE->LOAD on start=1 && stop=0; start && stop in IDLE keeps IDLE.
REQ-014 SHALL assert load=1 for exactly LOAD_CYCLES consecutive cycles in LOAD and in RELOAD, then enter RUN; load=0 in IDLE and RUN.
REQ-015 SHALL enter IDLE on the cycle after stop=1 from any non-IDLE state, including mid-LOAD/RELOAD; load drops with it. stop has priority over all other transitions.
REQ-016 SHALL clear the decimation counter to 0 on each RUN entry; in RUN, sample_valid=1 when counter==decim, then counter<=0, else counter<=counter+1. decim=0 gives sample_valid every RUN cycle; decim=3 gives the first pulse on the 4th RUN cycle.
REQ-017 SHALL keep sample_valid=0 outside RUN.
REQ-018 SHALL compute mag = (accu_re^2 + accu_im^2) >> 4 as 12-bit unsigned (sum is 16-bit unsigned; -128^2 handled exactly) and flag out-of-window when |mag - power| > tol, with power and tol zero-extended.
REQ-019 SHALL evaluate the window only on sample_valid cycles, using accu_re/accu_im on that same cycle.
REQ-020 SHALL go RUN->RELOAD after two consecutive evaluated samples are out-of-window; an in-window sample clears the miss count; the miss count clears on RUN entry.
REQ-021 SHALL increment relock_cnt on each RUN->RELOAD, saturating at 255; it clears only on reset or on IDLE->LOAD.
REQ-022 SHALL register all outputs; none depends combinationally on inputs.

Reset
REQ-023 SHALL, while rst=1, force: state IDLE, load=0, sample_valid=0, busy=0, relock_cnt=0, cfg_ready=1 (after release), counters 0.
REQ-024 SHALL reset registers to re_coeff 0x7D, im_coeff 0x1B, power 0x40, accu_re_init 0x20, accu_im_init 0x00, decim 0x00, tol 0x10.
REQ-025 SHALL abort any operation immediately on rst assertion mid-LOAD/RUN/RELOAD; there is no partial-load completion.

Structure
REQ-026 SHALL place the state enum, register address constants and register reset values in shared package qosc_pkg.
REQ-027 SHALL isolate the squared-magnitude window compare in sub-module qosc_mag_check (inputs accu_re, accu_im, power, tol; output out_of_window, combinational).

Verification
REQ-028 Reset then start with LOAD_CYCLES=2 -> load=1 for exactly 2 cycles, state=RUN next, sample_valid every cycle (decim=0).
REQ-029 Write decim=3 in IDLE, start -> sample_valid first on the 4th RUN cycle, then every 4 cycles. A cfg write attempted during RUN -> ignored, cfg_ready=0.
REQ-030 RUN with accu_re=0x20, accu_im=0x00 (mag=0x040), power=0x40 -> no RELOAD. Then accu_re=0x10 for two samples (mag=0x010, error 48>16) -> RELOAD, load=1 for 2 cycles, relock_cnt=1.
REQ-031 Exactly one out-of-window sample between in-window samples -> no RELOAD, relock_cnt unchanged.
REQ-032 stop on the 1st LOAD cycle -> IDLE next cycle, load=0. start && stop together in IDLE -> stays IDLE.
REQ-033 Force 256 relocks -> relock_cnt saturates at 0xFF. Assert rst mid-RUN -> all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/qosc_pkg.sv
// Shared types and constants for the quadrature oscillator controller.
// Holds the FSM encoding, the register map and the register reset values.
package qosc_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StRun    = 2'd2,
        StReload = 2'd3
    } qosc_state_e;

    localparam logic [2:0] AddrReCoeff   = 3'd0;
    localparam logic [2:0] AddrImCoeff   = 3'd1;
    localparam logic [2:0] AddrPower     = 3'd2;
    localparam logic [2:0] AddrAccuReIni = 3'd3;
    localparam logic [2:0] AddrAccuImIni = 3'd4;
    localparam logic [2:0] AddrDecim     = 3'd5;
    localparam logic [2:0] AddrTol       = 3'd6;

    localparam logic [7:0] RstReCoeff   = 8'h7D;
    localparam logic [7:0] RstImCoeff   = 8'h1B;
    localparam logic [7:0] RstPower     = 8'h40;
    localparam logic [7:0] RstAccuReIni = 8'h20;
    localparam logic [7:0] RstAccuImIni = 8'h00;
    localparam logic [7:0] RstDecim     = 8'h00;
    localparam logic [7:0] RstTol       = 8'h10;

    function automatic logic is_loading(qosc_state_e s);
        return (s == StLoad) || (s == StReload);
    endfunction

endpackage

// File: rtl/qosc_cfg_if.sv
// Register write handshake between a configuring master and the oscillator controller.
interface qosc_cfg_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/qosc_mag_check.sv
// Squared-magnitude window compare: |((re^2 + im^2) >> 4) - power| > tol.
module qosc_mag_check (
    input  logic [7:0] accu_re,
    input  logic [7:0] accu_im,
    input  logic [7:0] power,
    input  logic [7:0] tol,
    output logic       out_of_window
);
    logic [15:0] re_x, im_x, re_sq, im_sq, sum;
    logic [11:0] mag, pow_x, diff;

    // Sign-extend to 16 bits; the low 16 bits of the product are exact since |x|^2 <= 2^14.
    assign re_x  = {{8{accu_re[7]}}, accu_re};
    assign im_x  = {{8{accu_im[7]}}, accu_im};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign sum   = re_sq + im_sq;
    assign mag   = 12'(sum >> 4);
    assign pow_x = {4'b0, power};
    assign diff  = (mag >= pow_x) ? (mag - pow_x) : (pow_x - mag);

    assign out_of_window = diff > {4'b0, tol};
endmodule

// File: rtl/qosc_ctrl.sv
// Oscillator controller: config registers, load/run/relock sequencing and status.
// All outputs come straight from flops; next-state values are computed one cycle ahead.
module qosc_ctrl
    import qosc_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    qosc_cfg_if.slave   cfg,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  accu_re,
    input  logic [7:0]  accu_im,
    output logic        load,
    output logic [7:0]  re_coeff,
    output logic [7:0]  im_coeff,
    output logic [7:0]  power,
    output logic [7:0]  accu_re_init,
    output logic [7:0]  accu_im_init,
    output logic        sample_valid,
    output logic        busy,
    output logic [1:0]  state,
    output logic [7:0]  relock_cnt
);
    localparam logic [3:0] LdLast = 4'(LOAD_CYCLES - 1);

    qosc_state_e state_q, state_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic [7:0]  dec_q, dec_d;
    logic        miss_q, miss_d;
    logic [7:0]  relock_q, relock_d;
    logic        sv_q, sv_d;
    logic        load_q, busy_q, cfg_ready_q;
    logic [7:0]  re_coeff_q, im_coeff_q, power_q, accu_re_ini_q, accu_im_ini_q, decim_q, tol_q;
    logic        cfg_we, oow;

    assign cfg_we = cfg.cfg_valid && cfg_ready_q;

    qosc_mag_check u_mag_check (
        .accu_re       (accu_re),
        .accu_im       (accu_im),
        .power         (power_q),
        .tol           (tol_q),
        .out_of_window (oow)
    );

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = '0;
        dec_d    = '0;
        miss_d   = 1'b0;
        relock_d = relock_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d  = StLoad;
                    relock_d = '0;
                end
            end
            StLoad, StReload: begin
                if (stop)                    state_d  = StIdle;
                else if (ld_cnt_q == LdLast) state_d  = StRun;
                else                         ld_cnt_d = ld_cnt_q + 4'd1;
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    dec_d  = (dec_q == decim_q) ? 8'd0 : dec_q + 8'd1;
                    miss_d = miss_q;
                    if (sv_q) begin
                        if (!oow) begin
                            miss_d = 1'b0;
                        end else if (miss_q) begin
                            // Second consecutive miss: relock the oscillator.
                            state_d  = StReload;
                            dec_d    = '0;
                            miss_d   = 1'b0;
                            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
            end
        endcase
        sv_d = (state_d == StRun) && (dec_d == decim_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ld_cnt_q    <= '0;
            dec_q       <= '0;
            miss_q      <= 1'b0;
            relock_q    <= '0;
            sv_q        <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            dec_q       <= dec_d;
            miss_q      <= miss_d;
            relock_q    <= relock_d;
            sv_q        <= sv_d;
            load_q      <= is_loading(state_d);
            busy_q      <= state_d != StIdle;
            cfg_ready_q <= state_d == StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_coeff_q    <= RstReCoeff;
            im_coeff_q    <= RstImCoeff;
            power_q       <= RstPower;
            accu_re_ini_q <= RstAccuReIni;
            accu_im_ini_q <= RstAccuImIni;
            decim_q       <= RstDecim;
            tol_q         <= RstTol;
        end else if (cfg_we) begin
            case (cfg.cfg_addr)
                AddrReCoeff:   re_coeff_q    <= cfg.cfg_data;
                AddrImCoeff:   im_coeff_q    <= cfg.cfg_data;
                AddrPower:     power_q       <= cfg.cfg_data;
                AddrAccuReIni: accu_re_ini_q <= cfg.cfg_data;
                AddrAccuImIni: accu_im_ini_q <= cfg.cfg_data;
                AddrDecim:     decim_q       <= cfg.cfg_data;
                AddrTol:       tol_q         <= cfg.cfg_data;
                default: ;
            endcase
        end
    end

    assign cfg.cfg_ready  = cfg_ready_q;
    assign load           = load_q;
    assign busy           = busy_q;
    assign state          = state_q;
    assign sample_valid   = sv_q;
    assign relock_cnt     = relock_q;
    assign re_coeff       = re_coeff_q;
    assign im_coeff       = im_coeff_q;
    assign power          = power_q;
    assign accu_re_init   = accu_re_ini_q;
    assign accu_im_init   = accu_im_ini_q;
endmodule

// File: tb/tb_qosc_ctrl.sv
// Randomized and directed bench for qosc_ctrl against a cycle-level behavioural model.
module tb_qosc_ctrl;
    localparam int unsigned LC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [7:0] accu_re, accu_im;
    logic       load, sample_valid, busy;
    logic [7:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init, relock_cnt;
    logic [1:0] state;

    qosc_cfg_if cfg_bus ();

    qosc_ctrl #(.LOAD_CYCLES(LC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg_bus.slave),
        .start        (start),
        .stop         (stop),
        .accu_re      (accu_re),
        .accu_im      (accu_im),
        .load         (load),
        .re_coeff     (re_coeff),
        .im_coeff     (im_coeff),
        .power        (power),
        .accu_re_init (accu_re_init),
        .accu_im_init (accu_im_init),
        .sample_valid (sample_valid),
        .busy         (busy),
        .state        (state),
        .relock_cnt   (relock_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 load, 2 run, 3 reload
    int m_state, m_load_left, m_run_idx, m_miss, m_relock;
    int regs [7];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_load_left = 0; m_run_idx = 0; m_miss = 0; m_relock = 0;
        regs = '{125, 27, 64, 32, 0, 0, 16};
    endtask

    function automatic int exp_sv();
        return (m_state == 2 && (m_run_idx % (regs[5] + 1)) == regs[5]) ? 1 : 0;
    endfunction

    function automatic bit out_of_window(int re, int im);
        int mag, d;
        mag = (re * re + im * im) / 16;
        d = mag - regs[2];
        if (d < 0) d = -d;
        return d > regs[6];
    endfunction

    task automatic compare_outputs();
        check("state", int'(state), m_state);
        check("load", int'(load), (m_state == 1 || m_state == 3) ? 1 : 0);
        check("busy", int'(busy), (m_state != 0) ? 1 : 0);
        check("cfg_ready", int'(cfg_bus.cfg_ready), (m_state == 0) ? 1 : 0);
        check("sample_valid", int'(sample_valid), exp_sv());
        check("relock_cnt", int'(relock_cnt), m_relock);
        check("re_coeff", int'(re_coeff), regs[0]);
        check("im_coeff", int'(im_coeff), regs[1]);
        check("power", int'(power), regs[2]);
        check("accu_re_init", int'(accu_re_init), regs[3]);
        check("accu_im_init", int'(accu_im_init), regs[4]);
    endtask

    task automatic model_step();
        bit was_idle, sv;
        was_idle = (m_state == 0);
        sv = exp_sv() == 1;
        case (m_state)
            0: if (start && !stop) begin
                m_state = 1; m_load_left = LC; m_relock = 0;
            end
            1, 3: if (stop) m_state = 0;
            else begin
                m_load_left--;
                if (m_load_left == 0) begin m_state = 2; m_run_idx = 0; m_miss = 0; end
            end
            default: if (stop) m_state = 0;
            else begin
                if (sv) m_miss = out_of_window(int'($signed(accu_re)), int'($signed(accu_im)))
                               ? m_miss + 1 : 0;
                if (m_miss == 2) begin
                    m_state = 3; m_load_left = LC;
                    if (m_relock < 255) m_relock++;
                end else m_run_idx++;
            end
        endcase
        if (was_idle && cfg_bus.cfg_valid && cfg_bus.cfg_addr != 3'd7)
            regs[cfg_bus.cfg_addr] = int'(cfg_bus.cfg_data);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_data = d;
        cycle();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0; cycle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick_accu();
        case ($urandom_range(0, 4))
            0: return 8'h20;
            1: return 8'h10;
            2: return 8'hE0;
            3: return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; accu_re = 8'h20; accu_im = 8'h00;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
        #12;
        apply_reset();

        // Basic start, decim=0
        pulse_start();
        repeat (6) cycle();
        do_stop();

        // decim=3, then an ignored write during RUN
        write_reg(3'd5, 8'd3);
        write_reg(3'd7, 8'hAA);
        pulse_start();
        repeat (4) cycle();
        write_reg(3'd0, 8'h55);
        repeat (10) cycle();
        do_stop();

        // Window: in-window, two misses, recovery, then isolated misses
        write_reg(3'd5, 8'd0);
        pulse_start();
        repeat (4) cycle();
        accu_re = 8'h10; repeat (2) cycle();
        accu_re = 8'h20; repeat (6) cycle();
        for (int i = 0; i < 6; i++) begin
            accu_re = (i % 2 == 0) ? 8'h10 : 8'h20;
            cycle();
        end
        accu_re = 8'h20;
        do_stop();

        // stop on first LOAD cycle; start && stop in IDLE
        pulse_start();
        do_stop();
        start = 1'b1; stop = 1'b1; cycle();
        start = 1'b0; stop = 1'b0; repeat (2) cycle();

        // Relock saturation
        pulse_start();
        accu_re = 8'h10;
        repeat (1200) cycle();
        check("relock_sat", int'(relock_cnt), 255);

        // Async reset in RUN
        accu_re = 8'h20;
        pulse_start();
        repeat (4) cycle();
        #3;
        apply_reset();

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            cfg_bus.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_bus.cfg_addr  = 3'($urandom_range(0, 7));
            cfg_bus.cfg_data  = (cfg_bus.cfg_addr == 3'd5) ? 8'($urandom_range(0, 3))
                                                           : 8'($urandom_range(0, 255));
            accu_re = pick_accu();
            accu_im = ($urandom_range(0, 3) == 0) ? pick_accu() : 8'h00;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
